// File: rtl/bus_mux_rr.sv
// bus_mux_rr -- N-channel registered bus multiplexer with valid/ready handshakes.
//
// Arbitrates between N input channels (round-robin or fixed priority) and
// registers the winning beat onto a single output. A packet that is started
// (a beat accepted with last=0) locks the arbiter to its channel until the
// beat carrying last=1 is accepted, so multi-beat transfers never interleave.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Hyrja        in   N*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   Hyrja_valid  in   N   per-channel beat valid
//   Hyrja_last   in   N   per-channel end-of-packet flag
//   Hyrja_ready  out  N   per-channel accept (at most one bit high)
//   Dalja        out  WIDTH registered output data
//   Dalja_valid  out  output beat valid
//   Dalja_last   out  registered last flag of the output beat
//   Dalja_sel    out  SELW index of the channel that produced the output beat
//   Dalja_ready  in   consumer accepts the output beat
module bus_mux_rr #(
    parameter int WIDTH     = 24,
    parameter int N         = 4,
    parameter int FIXED_PRI = 0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N*WIDTH-1:0]     Hyrja,
    input  logic [N-1:0]           Hyrja_valid,
    input  logic [N-1:0]           Hyrja_last,
    output logic [N-1:0]           Hyrja_ready,
    output logic [WIDTH-1:0]       Dalja,
    output logic                   Dalja_valid,
    output logic                   Dalja_last,
    output logic [$clog2(N)-1:0]   Dalja_sel,
    input  logic                   Dalja_ready
);

    localparam int SELW = $clog2(N);
    localparam int unsigned NU = N;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } lock_state_t;

    lock_state_t        state, state_nx;
    logic [SELW-1:0]    lock_owner, owner_nx;
    logic [SELW-1:0]    rr_ptr, rr_nx;
    logic [SELW-1:0]    grant;
    logic               found;
    int unsigned        ptr_u;
    int unsigned        idx;
    logic               load;
    logic               gvalid;
    logic               accept;
    logic               beat_last;
    logic [WIDTH-1:0]   beat_data;

    // Output register is free when empty or being drained this cycle.
    assign load = !Dalja_valid || Dalja_ready;

    // Grant selection: lock owner first, otherwise fixed priority or a
    // round-robin scan starting just after the last packet's owner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        ptr_u = 32'(rr_ptr);
        idx   = 0;
        if (state == ARB_LOCKED) begin
            grant = lock_owner;
        end else if (FIXED_PRI != 0) begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (!found && Hyrja_valid[i]) begin
                    grant = SELW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NU; k++) begin
                idx = (ptr_u + k) % NU;
                if (!found && Hyrja_valid[idx]) begin
                    grant = SELW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Steer the granted channel and drive the one-hot ready vector.
    always_comb begin
        beat_data   = '0;
        beat_last   = 1'b0;
        gvalid      = 1'b0;
        Hyrja_ready = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (SELW'(i) == grant) begin
                beat_data      = Hyrja[i*WIDTH +: WIDTH];
                beat_last      = Hyrja_last[i];
                gvalid         = Hyrja_valid[i];
                Hyrja_ready[i] = load;
            end
        end
    end

    assign accept = load && gvalid;

    // Lock / fairness next state. rr_ptr only advances at packet ends, so
    // fairness is per packet rather than per beat.
    always_comb begin
        state_nx = state;
        owner_nx = lock_owner;
        rr_nx    = rr_ptr;
        if (accept) begin
            if (beat_last) begin
                state_nx = ARB_FREE;
                rr_nx    = grant;
            end else begin
                state_nx = ARB_LOCKED;
                owner_nx = grant;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ARB_FREE;
            lock_owner  <= '0;
            rr_ptr      <= SELW'(N - 1);
            Dalja       <= '0;
            Dalja_valid <= 1'b0;
            Dalja_last  <= 1'b0;
            Dalja_sel   <= '0;
        end else begin
            state      <= state_nx;
            lock_owner <= owner_nx;
            rr_ptr     <= rr_nx;
            if (accept) begin
                Dalja       <= beat_data;
                Dalja_last  <= beat_last;
                Dalja_sel   <= grant;
                Dalja_valid <= 1'b1;
            end else if (load) begin
                Dalja_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_rr.sv
// tb_bus_mux_rr -- scoreboard bench for bus_mux_rr.
//
// Three instances share one stimulus set: round-robin N=4, fixed-priority
// N=4 and round-robin N=8/WIDTH=16. `mode` selects which instance's outputs
// are observed and which instance's ready vector pops the channel sources.
module tb_bus_mux_rr;

    logic        Clock = 1'b0;
    logic        Reset;
    always #5 Clock = ~Clock;

    logic [23:0] cd [8];
    logic [7:0]  cv, cl;
    logic        dready;
    int          mode;

    logic [95:0]  bus_a;
    logic [127:0] bus_w;

    always_comb begin
        bus_a = '0;
        bus_w = '0;
        for (int i = 0; i < 4; i++) bus_a[i*24 +: 24] = cd[i];
        for (int i = 0; i < 8; i++) bus_w[i*16 +: 16] = cd[i][15:0];
    end

    logic [3:0]  a_ready, f_ready;
    logic [7:0]  w_ready;
    logic [23:0] a_dalja, f_dalja;
    logic [15:0] w_dalja;
    logic        a_dv, a_dl, f_dv, f_dl, w_dv, w_dl;
    logic [1:0]  a_ds, f_ds;
    logic [2:0]  w_ds;

    bus_mux_rr #(.WIDTH(24), .N(4), .FIXED_PRI(0)) u_rr (
        .Clock(Clock), .Reset(Reset), .Hyrja(bus_a), .Hyrja_valid(cv[3:0]),
        .Hyrja_last(cl[3:0]), .Hyrja_ready(a_ready), .Dalja(a_dalja),
        .Dalja_valid(a_dv), .Dalja_last(a_dl), .Dalja_sel(a_ds), .Dalja_ready(dready)
    );

    bus_mux_rr #(.WIDTH(24), .N(4), .FIXED_PRI(1)) u_fp (
        .Clock(Clock), .Reset(Reset), .Hyrja(bus_a), .Hyrja_valid(cv[3:0]),
        .Hyrja_last(cl[3:0]), .Hyrja_ready(f_ready), .Dalja(f_dalja),
        .Dalja_valid(f_dv), .Dalja_last(f_dl), .Dalja_sel(f_ds), .Dalja_ready(dready)
    );

    bus_mux_rr #(.WIDTH(16), .N(8), .FIXED_PRI(0)) u_w8 (
        .Clock(Clock), .Reset(Reset), .Hyrja(bus_w), .Hyrja_valid(cv),
        .Hyrja_last(cl), .Hyrja_ready(w_ready), .Dalja(w_dalja),
        .Dalja_valid(w_dv), .Dalja_last(w_dl), .Dalja_sel(w_ds), .Dalja_ready(dready)
    );

    logic [23:0] mon_dalja;
    logic        mon_valid, mon_last;
    logic [2:0]  mon_sel;
    logic [7:0]  mon_ready;

    always_comb begin
        mon_dalja = '0;
        mon_valid = 1'b0;
        mon_last  = 1'b0;
        mon_sel   = '0;
        mon_ready = '0;
        case (mode)
            0: begin
                mon_dalja = a_dalja; mon_valid = a_dv; mon_last = a_dl;
                mon_sel = {1'b0, a_ds}; mon_ready = {4'b0, a_ready};
            end
            1: begin
                mon_dalja = f_dalja; mon_valid = f_dv; mon_last = f_dl;
                mon_sel = {1'b0, f_ds}; mon_ready = {4'b0, f_ready};
            end
            default: begin
                mon_dalja = {8'h0, w_dalja}; mon_valid = w_dv; mon_last = w_dl;
                mon_sel = w_ds; mon_ready = w_ready;
            end
        endcase
    end

    // Channel sources: per-channel beat lists presented in order.
    logic [23:0] sd [8][16];
    logic        sl [8][16];
    int unsigned scnt [8];
    int unsigned spos [8];

    typedef struct packed {
        logic [23:0] data;
        logic [2:0]  sel;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    first_out, last_out;
    string cur_tag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic add_beat(input int unsigned c, input logic [23:0] d, input logic l);
        sd[c][scnt[c]] = d;
        sl[c][scnt[c]] = l;
        scnt[c]++;
    endtask

    task automatic expect_beat(input logic [23:0] d, input logic [2:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.sel  = s;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic refresh();
        for (int c = 0; c < 8; c++) begin
            if (spos[c] < scnt[c]) begin
                cv[c] = 1'b1;
                cd[c] = sd[c][spos[c]];
                cl[c] = sl[c][spos[c]];
            end else begin
                cv[c] = 1'b0;
                cd[c] = '0;
                cl[c] = 1'b0;
            end
        end
    endtask

    task automatic flush_sources();
        for (int c = 0; c < 8; c++) begin
            scnt[c] = 0;
            spos[c] = 0;
        end
        refresh();
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int c = 0; c < 8; c++) if (spos[c] < scnt[c]) p = 1'b1;
        return p;
    endfunction

    task automatic clear_span();
        first_out = -1;
        last_out  = -1;
    endtask

    // One clock: observe at the falling edge, advance sources after the rising edge.
    task automatic step(input bit hold);
        logic [7:0] fired;
        beat_t      b;
        @(negedge Clock);
        cyc++;
        fired = cv & mon_ready;
        if (hold) begin
            check({cur_tag, " hold valid"}, 32'(mon_valid), 32'd1);
            check({cur_tag, " hold data"},  32'(mon_dalja), 32'hABCDEF);
            check({cur_tag, " hold sel"},   32'(mon_sel),   32'd1);
            check({cur_tag, " hold last"},  32'(mon_last),  32'd1);
            check({cur_tag, " hold ready"}, 32'(mon_ready), 32'd0);
        end
        if (mon_valid && dready) begin
            if (exp_q.size() == 0) begin
                check({cur_tag, " unexpected beat"}, 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                check({cur_tag, " data"}, 32'(mon_dalja), 32'(b.data));
                check({cur_tag, " sel"},  32'(mon_sel),   32'(b.sel));
                check({cur_tag, " last"}, 32'(mon_last),  32'(b.last));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        @(posedge Clock);
        #1;
        for (int c = 0; c < 8; c++)
            if (fired[c] && spos[c] < scnt[c]) spos[c]++;
        refresh();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pending()) && n < budget) begin
            step(1'b0);
            n++;
        end
        check({cur_tag, " completed in budget"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode   = 0;
        dready = 1'b1;
        Reset  = 1'b0;
        flush_sources();
        cur_tag = "reset";
        #3;
        check("reset data",  32'(mon_dalja), 32'd0);
        check("reset valid", 32'(mon_valid), 32'd0);
        check("reset last",  32'(mon_last),  32'd0);
        check("reset sel",   32'(mon_sel),   32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // Four single-beat channels: plain per-beat round-robin, no bubbles.
        cur_tag = "t1";
        clear_span();
        add_beat(0, 24'h000011, 1'b1);
        add_beat(1, 24'h000022, 1'b1);
        add_beat(2, 24'h000033, 1'b1);
        add_beat(3, 24'h000044, 1'b1);
        expect_beat(24'h000011, 3'd0, 1'b1);
        expect_beat(24'h000022, 3'd1, 1'b1);
        expect_beat(24'h000033, 3'd2, 1'b1);
        expect_beat(24'h000044, 3'd3, 1'b1);
        refresh();
        drain(40);
        check("t1 span", 32'(last_out - first_out), 32'd3);

        // Channel 2 three-beat packet against a continuously valid channel 0.
        cur_tag = "t2";
        clear_span();
        for (int i = 0; i < 6; i++) add_beat(0, 24'h000100 + 24'(i), 1'b1);
        add_beat(2, 24'h0002A1, 1'b0);
        add_beat(2, 24'h0002A2, 1'b0);
        add_beat(2, 24'h0002A3, 1'b1);
        expect_beat(24'h000100, 3'd0, 1'b1);
        expect_beat(24'h0002A1, 3'd2, 1'b0);
        expect_beat(24'h0002A2, 3'd2, 1'b0);
        expect_beat(24'h0002A3, 3'd2, 1'b1);
        for (int i = 1; i < 6; i++) expect_beat(24'h000100 + 24'(i), 3'd0, 1'b1);
        refresh();
        drain(60);
        check("t2 span", 32'(last_out - first_out), 32'd8);

        // Backpressure: output held for 4 cycles, then back-to-back drain.
        cur_tag = "t3";
        dready = 1'b0;
        add_beat(1, 24'hABCDEF, 1'b1);
        add_beat(3, 24'h123456, 1'b1);
        refresh();
        step(1'b0);
        repeat (4) step(1'b1);
        clear_span();
        expect_beat(24'hABCDEF, 3'd1, 1'b1);
        expect_beat(24'h123456, 3'd3, 1'b1);
        dready = 1'b1;
        drain(40);
        check("t3 span", 32'(last_out - first_out), 32'd1);

        // Reset in the middle of a channel 1 packet.
        cur_tag = "t4";
        add_beat(1, 24'h000C10, 1'b0);
        add_beat(1, 24'h000C11, 1'b0);
        add_beat(1, 24'h000C12, 1'b0);
        add_beat(1, 24'h000C13, 1'b1);
        expect_beat(24'h000C10, 3'd1, 1'b0);
        refresh();
        step(1'b0);
        step(1'b0);
        Reset = 1'b0;
        #1;
        check("t4 async valid", 32'(mon_valid), 32'd0);
        check("t4 async data",  32'(mon_dalja), 32'd0);
        check("t4 async last",  32'(mon_last),  32'd0);
        flush_sources();
        step(1'b0);
        Reset = 1'b1;
        add_beat(0, 24'h000D00, 1'b1);
        add_beat(1, 24'h000D01, 1'b1);
        expect_beat(24'h000D00, 3'd0, 1'b1);
        expect_beat(24'h000D01, 3'd1, 1'b1);
        refresh();
        drain(40);

        // Fixed priority: channel 1 wins every cycle while it has beats.
        cur_tag = "t5";
        Reset = 1'b0;
        mode  = 1;
        flush_sources();
        step(1'b0);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            add_beat(1, 24'h000E10 + 24'(i), 1'b1);
            add_beat(3, 24'h000E30 + 24'(i), 1'b1);
        end
        for (int i = 0; i < 6; i++) expect_beat(24'h000E10 + 24'(i), 3'd1, 1'b1);
        for (int i = 0; i < 6; i++) expect_beat(24'h000E30 + 24'(i), 3'd3, 1'b1);
        refresh();
        drain(60);

        // N=8 wrap-around: rr_ptr=7 after reset, channels 0 and 7 alternate.
        cur_tag = "t6";
        Reset = 1'b0;
        mode  = 2;
        flush_sources();
        step(1'b0);
        Reset = 1'b1;
        add_beat(7, 24'h007701, 1'b1);
        add_beat(7, 24'h007702, 1'b1);
        add_beat(0, 24'h000001, 1'b1);
        add_beat(0, 24'h000002, 1'b1);
        expect_beat(24'h000001, 3'd0, 1'b1);
        expect_beat(24'h007701, 3'd7, 1'b1);
        expect_beat(24'h000002, 3'd0, 1'b1);
        expect_beat(24'h007702, 3'd7, 1'b1);
        refresh();
        drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_mux_rr.md
Name: bus_mux_rr

Overview:
- Parametrised successor to the CPU's combinational 4-to-1 selector.
- N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Arbitration is round-robin or fixed priority, with packet locking so a multi-beat transfer is not interleaved.
- Sits between multiple bus masters (fetch, load/store, DMA) and a single 24-bit datapath consumer.

Parameters:
- WIDTH, 24, data width per channel.
- N, 4, number of input channels; legal range 2..8.
- FIXED_PRI, 0: 0 = round-robin arbitration; 1 = fixed priority, lowest index wins.
- SELW, $clog2(N), localparam (derived, not overridable): width of the grant index.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- Hyrja  in  N*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- Hyrja_valid  in  N  channel i presents a beat.
- Hyrja_last  in  N  channel i's beat is the final beat of its packet.
- Hyrja_ready  out  N  channel i's beat is accepted this cycle.
- Dalja  out  WIDTH  registered output data.
- Dalja_valid  out  1  output beat valid.
- Dalja_last  out  1  registered copy of the accepted beat's last flag.
- Dalja_sel  out  SELW  index of the channel that produced the current output beat.
- Dalja_ready  in  1  consumer accepts the output beat.

Behaviour:
- Reset values (asynchronous on Reset=0): Dalja=0, Dalja_valid=0, Dalja_last=0, Dalja_sel=0, lock=0, lock_owner=0, rr_ptr=N-1, so channel 0 has first priority after reset.
- Reset asserted mid-packet discards the in-flight beat and the lock. No partial state survives.
- Load condition: load = !Dalja_valid || Dalja_ready (output register empty or draining this cycle).
- Grant (combinational):
  - if lock=1, grant = lock_owner;
  - else, round-robin: first i with Hyrja_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo N;
  - else, fixed priority (FIXED_PRI=1): lowest i with Hyrja_valid[i]=1.
  - gvalid = Hyrja_valid[grant].
- Hyrja_ready[i] = load && (i == grant). At most one bit is high. The ready bit may be high while that channel's valid is low.
- Accept occurs when Hyrja_valid[grant] && Hyrja_ready[grant]. On the next edge:
  - Dalja <= Hyrja[grant];
  - Dalja_last <= Hyrja_last[grant];
  - Dalja_sel <= grant;
  - Dalja_valid <= 1.
- When load=1 and no beat is accepted, Dalja_valid <= 0. Dalja and Dalja_sel hold their values.
- When load=0 (Dalja_valid=1, Dalja_ready=0), all output registers hold. Output is stable under backpressure; there is no combinational path from Dalja_ready to Dalja.
- Latency: 1 cycle from input accept to Dalja_valid. Throughput is 1 beat per cycle with Dalja_ready tied high.
- Lock state:
  - accept with Hyrja_last[grant]=0: lock <= 1, lock_owner <= grant;
  - accept with Hyrja_last[grant]=1: lock <= 0.
- While locked, Hyrja_valid[lock_owner]=0 produces no grant to other channels. The bubble is legal; the lock holds.
- rr_ptr updates only on an accept with last=1: rr_ptr <= grant. Fairness is per packet, not per beat. In FIXED_PRI mode rr_ptr is unused.
- Simultaneous output drain and new accept in one cycle is required. Back-to-back beats carry no bubble.
- Wrap-around: with rr_ptr=N-1 the scan begins at channel 0.
- Single-beat packets (last=1 on every beat) give plain per-beat round-robin.

Test Plan:
- Reset then all four channels valid with last=1, data 0x000011/0x000022/0x000033/0x000044, Dalja_ready=1 -> output 0x000011, 0x000022, 0x000033, 0x000044 on consecutive cycles, Dalja_sel 0,1,2,3.
- Channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is continuously valid -> Dalja_sel=2 for all 3 beats, then Dalja_sel=0. No interleave.
- Dalja_ready=0 for 4 cycles with Dalja=0xABCDEF valid -> Dalja, Dalja_sel and Dalja_last stable, Hyrja_ready all 0. Release -> next beat follows with no bubble.
- FIXED_PRI=1, channels 1 and 3 continuously valid -> Dalja_sel=1 every cycle; channel 3 starves, as required.
- Reset=0 asserted mid-packet from channel 1 -> Dalja_valid=0 immediately. After release, channel 0 is granted first (rr_ptr=N-1).
- N=8, WIDTH=16, rr_ptr=7, only channel 7 and channel 0 valid -> channel 0 granted first, then channel 7 (wrap-around).
